// File: rtl/adder_arb_pkg.sv
// -----------------------------------------------------------------------------
// adder_arb_pkg
// Shared definitions for the neuron adder arbiter:
//   state_t : arbiter FSM states (IDLE / ISSUE / RESP)
//   DATA_W  : operand/sum width, fixed by the shared Sklansky adder
//   clog2() : width of the encoded requester ID (at least 1 bit)
// -----------------------------------------------------------------------------
package adder_arb_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // A one-requester ID still needs a 1-bit field, so never return 0.
   function automatic int clog2(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage : adder_arb_pkg

// File: rtl/neuron_adder_arbiter_rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
// Combinational grant picker for the shared-adder arbiter.
//   ADDER_ARB_RR_EN defined   : round-robin, search starts at ptr and wraps.
//   ADDER_ARB_RR_EN undefined : fixed priority, lowest index wins; no ptr port.
// Ports:
//   req_valid [NREQ]  : requesters asking for the adder
//   ptr       [ID_W]  : round-robin start index (round-robin build only)
//   grant     [NREQ]  : one-hot grant, all zero when nobody is valid
//   grant_idx [ID_W]  : encoded index of the granted requester
// -----------------------------------------------------------------------------
module rr_grant
   import adder_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_valid,
`ifdef ADDER_ARB_RR_EN
   input  logic [ID_W-1:0] ptr,
`endif
   output logic [NREQ-1:0] grant,
   output logic [ID_W-1:0] grant_idx
);

   always_comb begin
      logic found;
      // NOTE: every variable driven here gets a default first, so no path
      // through the block leaves it unassigned and no latch is inferred.
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
`ifdef ADDER_ARB_RR_EN
      // First pass covers ptr..NREQ-1, second pass wraps around to 0..ptr-1.
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i] && (ID_W'(i) >= ptr)) begin
            grant[i]  = 1'b1;
            grant_idx = ID_W'(i);
            found     = 1'b1;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i]) begin
            grant[i]  = 1'b1;
            grant_idx = ID_W'(i);
            found     = 1'b1;
         end
      end
`else
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i]) begin
            grant[i]  = 1'b1;
            grant_idx = ID_W'(i);
            found     = 1'b1;
         end
      end
`endif
   end

endmodule : rr_grant

// File: rtl/neuron_adder_arbiter.sv
// -----------------------------------------------------------------------------
// neuron_adder_arbiter
// Shares one registered 8-bit adder (1-cycle latency) between NREQ neuron-side
// requesters. One operation runs at a time: accept (IDLE) -> add_start (ISSUE)
// -> response (RESP), so a new operation can start every 3 cycles at best.
// Build option: define ADDER_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority (lowest index wins).
// Ports:
//   clk, rst         : clock, synchronous active-high reset (also resets adder)
//   req_valid [NREQ] : requester i has an operand pair
//   req_ready [NREQ] : one-hot accept strobe (combinational, IDLE only)
//   req_a/req_b      : NREQ packed operand slices, slice i = requester i
//   rsp_valid [NREQ] : one-hot, sum available for the granted requester
//   rsp_ready [NREQ] : requester consumes the response
//   rsp_sum          : result, pass-through of add_sum
//   add_start        : one-cycle adder start strobe
//   add_a/add_b      : adder operands, hold their last value outside ISSUE
//   add_sum          : registered adder result
// -----------------------------------------------------------------------------
module neuron_adder_arbiter #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*DATA_W-1:0] req_a,
   input  logic [NREQ*DATA_W-1:0] req_b,
   output logic [NREQ-1:0]        rsp_valid,
   input  logic [NREQ-1:0]        rsp_ready,
   output logic [DATA_W-1:0]      rsp_sum,
   output logic                   add_start,
   output logic [DATA_W-1:0]      add_a,
   output logic [DATA_W-1:0]      add_b,
   input  logic [DATA_W-1:0]      add_sum
);

   localparam int ID_W = adder_arb_pkg::clog2(NREQ);
   localparam logic [NREQ-1:0] ONE_HOT_0 = {{(NREQ-1){1'b0}}, 1'b1};

   // The adder is an 8-bit Sklansky tree; any other width cannot be wired.
   if (DATA_W != adder_arb_pkg::DATA_W) begin : g_bad_data_w
      $error("neuron_adder_arbiter: DATA_W must equal adder_arb_pkg::DATA_W");
   end
   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("neuron_adder_arbiter: NREQ must be in 2..8");
   end

   adder_arb_pkg::state_t state_q, state_d;

   logic [NREQ-1:0]   grant;
   logic [ID_W-1:0]   grant_idx;
   logic [ID_W-1:0]   id_q;
   logic              accept;
   logic [DATA_W-1:0] a_sel;
   logic [DATA_W-1:0] b_sel;

   // ---------------------------------------------------------------- grant
`ifdef ADDER_ARB_RR_EN
   logic [ID_W-1:0] ptr_q;

   rr_grant #(.NREQ(NREQ), .ID_W(ID_W)) u_grant (
      .req_valid (req_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Next search starts just past the winner, wrapping at NREQ.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (accept) begin
         ptr_q <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end
   end
`else
   rr_grant #(.NREQ(NREQ), .ID_W(ID_W)) u_grant (
      .req_valid (req_valid),
      .grant     (grant),
      .grant_idx (grant_idx)
   );
`endif

   // One-hot grant drives an AND-OR mux over the packed operand slices.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            a_sel = req_a[i*DATA_W +: DATA_W];
            b_sel = req_b[i*DATA_W +: DATA_W];
         end
      end
   end

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // updates from the pre-edge values, independent of statement order.
      if (rst) begin
         state_q <= adder_arb_pkg::IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      accept    = 1'b0;
      unique case (state_q)
         adder_arb_pkg::IDLE: begin
            // Suppressed while rst is high so nothing is accepted in reset.
            if (!rst && (|grant)) begin
               req_ready = grant;
               accept    = 1'b1;
               state_d   = adder_arb_pkg::ISSUE;
            end
         end
         adder_arb_pkg::ISSUE: begin
            state_d = adder_arb_pkg::RESP;
         end
         adder_arb_pkg::RESP: begin
            // Only the granted requester's rsp_ready can close the response.
            if (rsp_ready[id_q]) begin
               state_d = adder_arb_pkg::IDLE;
            end
         end
         default: begin
            state_d = adder_arb_pkg::IDLE;
         end
      endcase
   end

   // ------------------------------------------------------ output registers
   // add_a/add_b double as the latched operand registers: loaded on accept,
   // presented during ISSUE, and simply held afterwards.
   always_ff @(posedge clk) begin
      // NOTE: the datapath registers are reset too because add_a/add_b are
      // visible outputs that must read zero after reset.
      if (rst) begin
         id_q      <= '0;
         add_a     <= '0;
         add_b     <= '0;
         add_start <= 1'b0;
         rsp_valid <= '0;
      end else begin
         add_start <= (state_d == adder_arb_pkg::ISSUE);
         rsp_valid <= (state_d == adder_arb_pkg::RESP) ? (ONE_HOT_0 << id_q) : '0;
         if (accept) begin
            id_q  <= grant_idx;
            add_a <= a_sel;
            add_b <= b_sel;
         end
      end
   end

   // add_sum is stable during RESP because no new start is issued there.
   assign rsp_sum = add_sum;

endmodule : neuron_adder_arbiter
